// File: rtl/path_test_scheduler.sv
// Sweeps every path with a low-to-high then high-to-low transition test and records failures.
// Moore outputs; one sweep is NUM_PATHS*2*(SETTLE_CYCLES+LAUNCH_CYCLES+1) cycles; abort returns to IDLE next edge.
module path_test_scheduler #(
    parameter int NUM_PATHS     = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int LAUNCH_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           pathResult,
    output logic                           pathInput,
    output logic [$clog2(NUM_PATHS)-1:0]   path_sel,
    output logic                           dir,
    output logic                           ld_reg,
    output logic                           busy,
    output logic                           fin,
    output logic [NUM_PATHS-1:0]           fail_vec,
    output logic [$clog2(NUM_PATHS+1)-1:0] fail_count
);

    localparam int PW   = $clog2(NUM_PATHS);
    localparam int FCW  = $clog2(NUM_PATHS + 1);
    localparam int MAXC = (SETTLE_CYCLES > LAUNCH_CYCLES) ? SETTLE_CYCLES : LAUNCH_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [PW-1:0] LAST_PATH = PW'(NUM_PATHS - 1);
    localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LAUNCH_END = CW'(LAUNCH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESET,
        S_LAUNCH,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [PW-1:0]          path_sel_q, path_sel_d;
    logic                   dir_q, dir_d;
    logic [NUM_PATHS-1:0]   fail_vec_q, fail_vec_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            path_sel_q <= '0;
            dir_q      <= 1'b0;
            fail_vec_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            path_sel_q <= path_sel_d;
            dir_q      <= dir_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        path_sel_d = path_sel_q;
        dir_d      = dir_q;
        fail_vec_d = fail_vec_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_PRESET;
                    cnt_d      = '0;
                    path_sel_d = '0;
                    dir_d      = 1'b0;
                    fail_vec_d = '0;
                end
            end
            S_PRESET: begin
                if (cnt_q == SETTLE_END) begin
                    state_d = S_LAUNCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LAUNCH: begin
                if (cnt_q == LAUNCH_END) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAPTURE: begin
                // The endpoint should now hold the launched level ~dir.
                if (pathResult == dir_q) begin
                    fail_vec_d[path_sel_q] = 1'b1;
                end
                cnt_d = '0;
                if (!dir_q) begin
                    dir_d   = 1'b1;
                    state_d = S_PRESET;
                end else if (path_sel_q != LAST_PATH) begin
                    path_sel_d = path_sel_q + PW'(1);
                    dir_d      = 1'b0;
                    state_d    = S_PRESET;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort keeps the capture sample taken above but discards any progress.
        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            path_sel_d = path_sel_q;
            dir_d      = dir_q;
        end
    end

    always_comb begin
        pathInput = 1'b0;
        ld_reg    = 1'b0;
        busy      = (state_q != S_IDLE);
        fin       = (state_q == S_DONE);
        case (state_q)
            S_PRESET:  pathInput = dir_q;
            S_LAUNCH:  pathInput = ~dir_q;
            S_CAPTURE: begin
                pathInput = ~dir_q;
                ld_reg    = 1'b1;
            end
            default:   pathInput = 1'b0;
        endcase
    end

    always_comb begin
        fail_count = '0;
        for (int i = 0; i < NUM_PATHS; i++) begin
            fail_count = fail_count + FCW'(fail_vec_q[i]);
        end
    end

    assign path_sel = path_sel_q;
    assign dir      = dir_q;
    assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_path_test_scheduler.sv
// Bench for path_test_scheduler with 4 paths, settle 2, launch 3 (6 cycles per test, 48 per sweep).
module tb_path_test_scheduler;

    logic       clk = 1'b0;
    logic       rst, start, abort, pathResult;
    logic       pathInput, dir, ld_reg, busy, fin;
    logic [1:0] path_sel;
    logic [3:0] fail_vec;
    logic [2:0] fail_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Per-path fault model: 0 good (1-cycle delayed), 1 stuck-at-0, 2 stuck-at-1, 3 inverting.
    int   fault [4];
    logic in_d1 = 1'b0;

    path_test_scheduler #(
        .NUM_PATHS(4),
        .SETTLE_CYCLES(2),
        .LAUNCH_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .pathResult(pathResult),
        .pathInput(pathInput),
        .path_sel(path_sel),
        .dir(dir),
        .ld_reg(ld_reg),
        .busy(busy),
        .fin(fin),
        .fail_vec(fail_vec),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) in_d1 <= pathInput;

    always_comb begin
        case (fault[path_sel])
            0:       pathResult = in_d1;
            1:       pathResult = 1'b0;
            2:       pathResult = 1'b1;
            default: pathResult = ~pathInput;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Test k covers path k/2, direction k%2; the path must end at the launched level.
    function automatic bit test_fails(input int k);
        int f;
        int d;
        f = fault[k / 2];
        d = k % 2;
        return (f == 3) || (f == 1 && d == 0) || (f == 2 && d == 1);
    endfunction

    // Failures become visible once the edge closing the test's capture cycle has passed.
    function automatic logic [3:0] fv_at(input int t);
        logic [3:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) begin
            if (6 * k + 6 <= t && test_fails(k)) v[k / 2] = 1'b1;
        end
        return v;
    endfunction

    task automatic set_faults(input int f0, input int f1, input int f2, input int f3);
        fault[0] = f0; fault[1] = f1; fault[2] = f2; fault[3] = f3;
    endtask

    task automatic check_idle(input string tag, input logic [3:0] fv);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " fin"}, fin, 0);
        chk({tag, " pin"}, pathInput, 0);
        chk({tag, " ld"}, ld_reg, 0);
        chk({tag, " fvec"}, fail_vec, fv);
        chk({tag, " fcnt"}, fail_count, $countones(fv));
    endtask

    // Runs one sweep. stop_at >= 0 aborts (or resets if use_rst) during that cycle.
    task automatic sweep(input string name, input int stop_at, input bit use_rst, input int glitch_at);
        int  test, pos, d;
        bit  stopped;
        logic [3:0] fv;
        stopped = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 48; t++) begin
            if (t == glitch_at) start = 1'b1;
            if (t == stop_at) begin
                if (use_rst) rst = 1'b1;
                else abort = 1'b1;
            end
            test = t / 6;
            pos  = t % 6;
            d    = test % 2;
            fv   = fv_at(t);
            @(negedge clk);
            chk($sformatf("%s pin t=%0d", name, t), pathInput, (pos < 2) ? d : 1 - d);
            chk($sformatf("%s ld t=%0d", name, t), ld_reg, pos == 5);
            chk($sformatf("%s dir t=%0d", name, t), dir, d);
            chk($sformatf("%s sel t=%0d", name, t), path_sel, test / 2);
            chk($sformatf("%s busy t=%0d", name, t), busy, 1);
            chk($sformatf("%s fin t=%0d", name, t), fin, 0);
            chk($sformatf("%s fvec t=%0d", name, t), fail_vec, fv);
            chk($sformatf("%s fcnt t=%0d", name, t), fail_count, $countones(fv));
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            if (t == stop_at) begin
                stopped = 1;
                break;
            end
        end
        if (stopped) begin
            fv = use_rst ? 4'b0000 : fv_at(stop_at + 1);
            check_idle({name, " stop"}, fv);
            if (use_rst) begin
                chk({name, " rst sel"}, path_sel, 0);
                chk({name, " rst dir"}, dir, 0);
            end
            repeat (3) begin
                @(posedge clk); #1;
                check_idle({name, " after"}, fv);
            end
        end else begin
            fv = fv_at(48);
            chk({name, " done fin"}, fin, 1);
            chk({name, " done busy"}, busy, 1);
            chk({name, " done pin"}, pathInput, 0);
            chk({name, " done sel"}, path_sel, 3);
            chk({name, " done fvec"}, fail_vec, fv);
            @(posedge clk); #1;
            check_idle({name, " end"}, fv);
            chk({name, " hold sel"}, path_sel, 3);
            @(posedge clk); #1;
            check_idle({name, " hold"}, fv);
        end
    endtask

    initial begin
        set_faults(0, 0, 0, 0);
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset", 4'b0000);
        chk("reset sel", path_sel, 0);
        chk("reset dir", dir, 0);

        // Reset outranks start.
        start = 1'b1;
        @(posedge clk); #1;
        chk("rst+start busy", busy, 0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;

        sweep("clean", -1, 0, -1);
        chk("clean fvec", fail_vec, 4'b0000);

        set_faults(0, 0, 1, 0);
        sweep("p2s0", -1, 0, -1);
        chk("p2s0 fvec", fail_vec, 4'b0100);
        chk("p2s0 fcnt", fail_count, 1);

        set_faults(3, 3, 3, 3);
        sweep("inv", -1, 0, -1);
        chk("inv fvec", fail_vec, 4'b1111);
        chk("inv fcnt", fail_count, 4);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) fault[i] = $urandom_range(0, 3);
            sweep($sformatf("rnd%0d", r), -1, 0, -1);
        end

        set_faults(3, 0, 0, 0);
        sweep("abort_launch", 14, 0, -1);
        chk("abort_launch fvec", fail_vec, 4'b0001);

        set_faults(2, 0, 0, 0);
        sweep("abort_cap", 11, 0, -1);
        chk("abort_cap fvec", fail_vec, 4'b0001);

        set_faults(1, 0, 0, 0);
        sweep("rst_mid", 20, 1, 3);

        set_faults(0, 3, 0, 2);
        sweep("recover", -1, 0, -1);
        chk("recover fvec", fail_vec, 4'b1010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
